// File: rtl/adc5g_tx_pkg.sv
// Shared encodings and sizing for the 5G ADC frame transmitter.
// Mode values match the control register field driven into the mode port.
package adc5g_tx_pkg;

  typedef enum logic [1:0] {
    MODE_RAMP  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_FIFO  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DW_DEF      = 4;
  localparam int NLANE_DEF   = 8;
  localparam int FRAME_W_DEF = 2 * NLANE_DEF * DW_DEF;

  function automatic int frame_w(input int dw, input int nlane);
    return 2 * nlane * dw;
  endfunction

endpackage

// File: rtl/adc5g_tx_fifo.sv
// Synchronous frame FIFO; head word is readable combinationally from rdata.
// Status comes from the registered count, so a pop never frees space in the same cycle.
module adc5g_tx_fifo
  import adc5g_tx_pkg::*;
#(
  parameter int W     = FRAME_W_DEF,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; contents are only visible once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/adc_5g_frame_tx.sv
// Stand-in for the 5G ADC demux receiver: emits I/Q lane frames, sync, overrange and valid
// from an internal pattern generator or from frames queued through a valid/ready port.
module adc_5g_frame_tx
  import adc5g_tx_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int NLANE       = NLANE_DEF,
  parameter int SYNC_PERIOD = 1024,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                      ctrl_clk_in,
  input  logic                      ctrl_reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [DW-1:0]             const_val,
  input  logic                      clr_underflow,
  input  logic [2*NLANE*DW-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NLANE*DW-1:0]       out_datai,
  output logic [NLANE*DW-1:0]       out_dataq,
  output logic [1:0]                out_outofrange,
  output logic [3:0]                out_sync,
  output logic                      out_data_valid,
  output logic                      underflow
);

  localparam int FW = frame_w(DW, NLANE);
  localparam int LW = NLANE * DW;
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e          state;
  mode_e           mode_q;
  logic            pre_cnt;
  logic [SW-1:0]   sync_cnt;
  logic [DW-1:0]   base;
  logic [FW-1:0]   fifo_rdata;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            run_act;
  logic            pop;
  logic            src_valid;
  logic [LW-1:0]   src_i;
  logic [LW-1:0]   src_q;

  function automatic logic any_ones(input logic [LW-1:0] v);
    logic r;
    r = 1'b0;
    for (int k = 0; k < NLANE; k++) begin
      if (&v[k*DW +: DW]) r = 1'b1;
    end
    return r;
  endfunction

  assign mode_q   = mode_e'(mode);
  assign in_ready = (fifo_count < CW'(FIFO_DEPTH));

  // The PRE->RUN edge already registers RUN cycle 0, so the first frame lands in the first RUN cycle.
  assign run_act  = enable && ((state == ST_PRE && pre_cnt) || state == ST_RUN);
  assign pop      = run_act && (mode_q == MODE_FIFO) && !fifo_empty;

  adc5g_tx_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ctrl_clk_in),
    .rst   (ctrl_reset),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    src_i     = '0;
    src_q     = '0;
    src_valid = 1'b1;
    case (mode_q)
      MODE_RAMP: begin
        for (int k = 0; k < NLANE; k++) begin
          src_i[k*DW +: DW] = base + DW'(k);
          src_q[k*DW +: DW] = base + DW'(NLANE + k);
        end
      end
      MODE_CONST: begin
        src_i = {NLANE{const_val}};
        src_q = {NLANE{const_val}};
      end
      MODE_FIFO: begin
        src_i     = fifo_rdata[LW-1:0];
        src_q     = fifo_rdata[FW-1:LW];
        src_valid = !fifo_empty;
      end
      default: begin
        src_i = {LW{sync_cnt[0]}};
        src_q = {LW{sync_cnt[0]}};
      end
    endcase
  end

  always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state          <= ST_IDLE;
      pre_cnt        <= 1'b0;
      sync_cnt       <= '0;
      base           <= '0;
      out_datai      <= '0;
      out_dataq      <= '0;
      out_outofrange <= 2'b00;
      out_sync       <= 4'h0;
      out_data_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          pre_cnt <= 1'b0;
          if (enable) state <= ST_PRE;
        end
        ST_PRE: begin
          if (!enable)     state <= ST_IDLE;
          else if (pre_cnt) state <= ST_RUN;
          else             pre_cnt <= 1'b1;
        end
        ST_RUN: begin
          if (!enable) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (run_act) begin
        sync_cnt <= sync_cnt + 1'b1;
        base     <= base + DW'(2 * NLANE);
        out_sync <= {4{sync_cnt == '0}};
        if (src_valid) begin
          out_datai      <= src_i;
          out_dataq      <= src_q;
          out_outofrange <= {any_ones(src_q), any_ones(src_i)};
          out_data_valid <= 1'b1;
        end else begin
          out_outofrange <= 2'b00;
          out_data_valid <= 1'b0;
        end
      end else begin
        sync_cnt       <= '0;
        base           <= '0;
        out_datai      <= '0;
        out_dataq      <= '0;
        out_outofrange <= 2'b00;
        out_sync       <= 4'h0;
        out_data_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ctrl_clk_in or posedge ctrl_reset) begin
    if (ctrl_reset)                                          underflow <= 1'b0;
    else if (clr_underflow)                                  underflow <= 1'b0;
    else if (run_act && mode_q == MODE_FIFO && fifo_empty)   underflow <= 1'b1;
  end

endmodule
